// File: rtl/pipe_hazard_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_if
// Bundles the signals exchanged between the MIPS pipeline datapath and the
// hazard/forwarding controller.
//   instr_d   : instruction currently held in the F/D register
//   flush     : exception/eret taken in M (kills D, E, M)
//   stall     : freeze PC and F/D, insert bubble into E
//   fwd_rs_d  : D-stage rs source   00 GRF, 01 E, 10 M, 11 W
//   fwd_rt_d  : D-stage rt source   00 GRF, 01 E, 10 M, 11 W
//   fwd_rs_e  : E-stage rs source   00 register value, 10 M, 11 W
//   fwd_rt_e  : E-stage rt source   00 register value, 10 M, 11 W
//   md_busy   : multiply/divide unit busy
// master = pipeline side, slave = controller side.
// -----------------------------------------------------------------------------
interface pipe_hazard_if;
  logic [31:0] instr_d;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic [1:0]  fwd_rs_e;
  logic [1:0]  fwd_rt_e;
  logic        md_busy;

  modport master (
    output instr_d, flush,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

  modport slave (
    input  instr_d, flush,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and forwarding controller for the five-stage MIPS core (F/D/E/M/W).
// Decodes the D-stage instruction into source-use deadlines (Tuse) and a
// result-ready time (Tnew), tracks {dest, tnew} for E, M and W, and derives
// stall and forwarding selects combinationally. Also owns the busy counter of
// the multiply/divide unit.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pipe_hazard_if.slave (instr_d, flush in; stall, fwd_*, md_busy out)
// Parameters:
//   MULT_CYCLES : busy cycles for mult/multu (>=1)
//   DIV_CYCLES  : busy cycles for div/divu (>=1)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  pipe_hazard_if.slave bus
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW     = $clog2(MD_MAX + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_COP0    = 6'h10;

  typedef struct packed {
    logic [4:0] dest;
    logic [1:0] tnew;
  } stage_t;

  localparam stage_t BUBBLE = '{dest: 5'd0, tnew: 2'd0};

  // Instruction fields
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = bus.instr_d[31:26];
  assign rs    = bus.instr_d[25:21];
  assign rt    = bus.instr_d[20:16];
  assign rd    = bus.instr_d[15:11];
  assign funct = bus.instr_d[5:0];

  // The shift amount never influences hazards.
  logic unused_shamt;
  assign unused_shamt = ^bus.instr_d[10:6];

  // Decoded D-stage attributes
  logic       use_rs, use_rt;
  logic [1:0] tuse_rs, tuse_rt;
  logic [4:0] dest_d;
  logic [1:0] tnew_d;
  logic       is_md;      // touches HI/LO: mult*/div*/mfhi/mflo/mthi/mtlo
  logic       is_muldiv;  // starts the multiply/divide unit

  always_comb begin
    // NOTE: every output of this block gets a default first so that no decode
    // path leaves one unassigned, which would otherwise infer a latch.
    use_rs    = 1'b0;
    tuse_rs   = 2'd0;
    use_rt    = 1'b0;
    tuse_rt   = 2'd0;
    dest_d    = 5'd0;
    tnew_d    = 2'd0;
    is_md     = 1'b0;
    is_muldiv = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          // ALU R-type and variable shifts read both sources in E
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
          6'h04, 6'h06, 6'h07: begin
            use_rs = 1'b1; tuse_rs = 2'd1;
            use_rt = 1'b1; tuse_rt = 2'd1;
            dest_d = rd;   tnew_d  = 2'd1;
          end
          // sll/srl/sra: rs field carries no operand
          6'h00, 6'h02, 6'h03: begin
            use_rt = 1'b1; tuse_rt = 2'd1;
            dest_d = rd;   tnew_d  = 2'd1;
          end
          6'h08: use_rs = 1'b1;                                 // jr
          6'h09: begin use_rs = 1'b1; dest_d = rd; end          // jalr, link ready at E
          6'h10, 6'h12: begin                                   // mfhi/mflo
            is_md = 1'b1; dest_d = rd; tnew_d = 2'd1;
          end
          6'h11, 6'h13: begin                                   // mthi/mtlo
            is_md = 1'b1; use_rs = 1'b1; tuse_rs = 2'd1;
          end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin                     // mult*/div*
            is_md  = 1'b1; is_muldiv = 1'b1;
            use_rs = 1'b1; tuse_rs   = 2'd1;
            use_rt = 1'b1; tuse_rt   = 2'd1;
          end
          default: ;
        endcase
      end
      OP_REGIMM, 6'h06, 6'h07: use_rs = 1'b1;                   // bltz/bgez/blez/bgtz
      OP_JAL: dest_d = 5'd31;
      6'h04, 6'h05: begin use_rs = 1'b1; use_rt = 1'b1; end    // beq/bne
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin    // ALU I-type
        use_rs = 1'b1; tuse_rs = 2'd1; dest_d = rt; tnew_d = 2'd1;
      end
      6'h0f: begin dest_d = rt; tnew_d = 2'd1; end              // lui
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin                  // loads
        use_rs = 1'b1; tuse_rs = 2'd1; dest_d = rt; tnew_d = 2'd2;
      end
      6'h28, 6'h29, 6'h2b: begin                                // stores: data needed in M
        use_rs = 1'b1; tuse_rs = 2'd1; use_rt = 1'b1; tuse_rt = 2'd2;
      end
      OP_COP0: begin
        if (rs == 5'd0) begin                                   // mfc0
          dest_d = rt; tnew_d = 2'd2;
        end else if (rs == 5'd4) begin                          // mtc0
          use_rt = 1'b1; tuse_rt = 2'd2;
        end
      end
      default: ;
    endcase
  end

  // Pipeline tracking state
  stage_t        e_q, m_q, w_q;
  logic [4:0]    rs_e, rt_e;   // source registers of the instruction in E
  logic [CW-1:0] md_cnt;

  logic md_busy;
  assign md_busy = (md_cnt != '0);

  function automatic logic src_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                      input stage_t e, input stage_t m);
    return (r != 5'd0) &&
           ((r == e.dest && e.tnew > tuse) || (r == m.dest && m.tnew > tuse));
  endfunction

  logic data_stall, md_stall, stall;
  assign data_stall = (use_rs && src_hazard(rs, tuse_rs, e_q, m_q)) ||
                      (use_rt && src_hazard(rt, tuse_rt, e_q, m_q));
  assign md_stall   = is_md && md_busy;
  assign stall      = data_stall || md_stall;

  // Youngest matching ready producer wins; the select code names the stage.
  function automatic logic [1:0] fwd_d_sel(input logic [4:0] r, input stage_t e,
                                           input stage_t m, input stage_t w);
    if (r == 5'd0)                        return 2'b00;
    if (e.dest == r && e.tnew == 2'd0)    return 2'b01;
    if (m.dest == r && m.tnew == 2'd0)    return 2'b10;
    if (w.dest == r && w.tnew == 2'd0)    return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] r, input stage_t m,
                                           input stage_t w);
    if (r == 5'd0)                        return 2'b00;
    if (m.dest == r && m.tnew == 2'd0)    return 2'b10;
    if (w.dest == r && w.tnew == 2'd0)    return 2'b11;
    return 2'b00;
  endfunction

  assign bus.stall    = stall;
  assign bus.md_busy  = md_busy;
  assign bus.fwd_rs_d = fwd_d_sel(rs, e_q, m_q, w_q);
  assign bus.fwd_rt_d = fwd_d_sel(rt, e_q, m_q, w_q);
  assign bus.fwd_rs_e = fwd_e_sel(rs_e, m_q, w_q);
  assign bus.fwd_rt_e = fwd_e_sel(rt_e, m_q, w_q);

  // Stage entries. Flush beats stall: the D instruction is killed either way.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of e_q/m_q regardless of statement order.
    if (reset || bus.flush) begin
      e_q  <= BUBBLE;
      m_q  <= BUBBLE;
      w_q  <= BUBBLE;
      rs_e <= 5'd0;
      rt_e <= 5'd0;
    end else begin
      if (stall) begin
        e_q  <= BUBBLE;
        rs_e <= 5'd0;
        rt_e <= 5'd0;
      end else begin
        e_q  <= '{dest: dest_d, tnew: tnew_d};
        rs_e <= rs;
        rt_e <= rt;
      end
      m_q <= '{dest: e_q.dest, tnew: (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0};
      w_q <= '{dest: m_q.dest, tnew: 2'd0};
    end
  end

  // Multiply/divide busy counter. Only a real issue into E reloads it; flush
  // leaves an in-flight operation running.
  logic md_start;
  assign md_start = is_muldiv && !stall && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start) begin
      md_cnt <= funct[1] ? DIV_LD : MULT_LD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and forwarding controller for the five-stage MIPS core (F/D/E/M/W). It decodes the Decode-stage instruction into source-use deadlines (Tuse) and result-ready times (Tnew), and tracks destination registers through E, M and W. From these it drives the stall, bubble and forwarding selects. It also owns a configurable-latency busy counter for the multiply/divide unit and honours the exception/eret flush from M.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr_d  in  32  instruction currently in D
- flush  in  1  exception/eret taken in M; kills D, E, M
- stall  out  1  freeze PC and F/D register; insert bubble into E
- fwd_rs_d, fwd_rt_d  out  2 each  D-stage operand source: 00 GRF, 01 E, 10 M, 11 W
- fwd_rs_e, fwd_rt_e  out  2 each  E-stage operand source: 00 register file value, 10 M, 11 W
- md_busy  out  1  multiply/divide unit busy

## Operation
- Decode classes for instr_d:
  - rs Tuse=0: beq/bne/blez/bgtz/bltz/bgez/jr/jalr.
  - rs Tuse=1: ALU R/I types, loads, stores, mult*/div*, mthi/mtlo.
  - rt Tuse=0: beq/bne.
  - rt Tuse=1: R-type ALU, shifts, mult*/div*.
  - rt Tuse=2: sw/sh/sb, mtc0.
- Tnew at E entry:
  - loads, mfc0: 2.
  - ALU, lui, shifts, mfhi/mflo: 1.
  - jal/jalr: 0.
  - No destination (stores, branches, j, jr, mult*/div*, mt*, eret, nop, unknown opcode): dest=0.
- Destination: rd for R-type/jalr, rt for I-type/mfc0, 31 for jal.
- Stage entries {dest[4:0], tnew[1:0]} for E, M, W:
  - E ← decoded D, or bubble (dest=0) when stall or flush.
  - M ← E with tnew=max(tnew−1,0).
  - W ← M with tnew=0.
- Stall (combinational):
  - Source hazard: any used source with reg≠0 matching E.dest with E.tnew>Tuse, or matching M.dest with M.tnew>Tuse.
  - MD hazard: instr_d is mult*/div*/mfhi/mflo/mthi/mtlo and md_busy=1.
- Forward priority is youngest first; only for reg≠0 and a matching entry with tnew=0.
  - D: E, then M, then W.
  - E: held sources of the E instruction, M, then W.
- MD counter, width clog2(max(MULT,DIV)+1):
  - Loads MULT_CYCLES/DIV_CYCLES on the edge a mult*/div* enters E (not bubbled).
  - Otherwise decrements to 0.
  - md_busy = cnt≠0.
- Flush:
  - E and M cleared to bubble at the next edge; W receives a bubble.
  - The MD counter is not affected; an in-flight operation completes.
- Writes to $0 never create hazards or forwards.

## Timing
- Reset, next edge:
  - All entries bubble, cnt=0.
  - Outputs: stall=0, md_busy=0, all fwd=00.
- stall and fwd_* are combinational from instr_d and registered state in the same cycle. No added latency.
- Stall and flush in the same cycle: flush wins for the E/M/W entries; stall still asserts if its condition holds.
- Reset mid-MD operation clears cnt; md_busy drops the cycle after the reset edge.
- A mult*/div* in D while busy stalls and does not reload the counter until it enters E.

## Test plan
- lw $1,0($0) then addu $2,$1,$3:
  - stall=1 for exactly 1 cycle.
  - Next cycle, with addu in E, fwd_rs_e=11.
- lw $1 then beq $1,$0:
  - stall=1 for 2 cycles.
  - Then fwd_rs_d=11.
- addu $1 then beq $1,$2:
  - stall=1 for 1 cycle.
  - Then fwd_rs_d=10 and fwd_rt_d=00.
- jal then jr $31: stall=0 and fwd_rs_d=01 in the cycle jr is in D.
- mult then mflo:
  - stall=1 for 5 cycles; md_busy falls after 5 cycles.
  - With DIV_CYCLES=10, div then mfhi stalls 10 cycles.
- Flush and reset cases:
  - addu $0,… then beq $0: no stall, fwd=00.
  - flush with lw in E: entries cleared, no stall next cycle.
  - reset during div: md_busy=0 after the edge.
